// File: rtl/datapath_pkg.sv
// Shared datapath definitions: word width, divider state encoding and iteration count.
package datapath_pkg;

    localparam int WORD_W    = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes, purely combinational.
module div_step
    import datapath_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quot_nxt
);

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   diff;

    // rem < divisor always holds, so the shifted remainder still fits in WIDTH bits
    assign rem_sh   = {rem[WIDTH-2:0], quot[WIDTH-1]};
    assign diff     = {1'b0, rem_sh} - {1'b0, divisor};
    assign rem_nxt  = diff[WIDTH] ? rem_sh : diff[WIDTH-1:0];
    assign quot_nxt = {quot[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: 32 restoring steps on magnitudes plus one sign-fix cycle.
//   state | meaning
//   IDLE  | waiting for start; also retires a pending divide-by-zero result
//   CALC  | one restoring iteration per cycle
//   FIX   | apply signs, write quotient/remainder, pulse done
module div_unit
    import datapath_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] rem_q, quot_q, dsr_q;
    logic [WIDTH-1:0] rem_nxt, quot_nxt;
    logic [WIDTH-1:0] abs_dividend, abs_divisor;
    logic [5:0]       cnt;
    logic             neg_quot, neg_rem;
    logic             dbz_pend;
    logic             accept;

    assign abs_dividend = dividend[WIDTH-1] ? -dividend : dividend;
    assign abs_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
    // a pending divide-by-zero result occupies the cycle, so start is not sampled then
    assign accept       = (state == IDLE) && start && !dbz_pend;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (dsr_q),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && (divisor != '0)) state_nxt = CALC;
            CALC:    if (cnt == LAST_ITER)          state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dsr_q       <= '0;
            cnt         <= '0;
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_pend    <= 1'b0;
        end else begin
            done     <= 1'b0;
            dbz_pend <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dbz_pend) begin
                        quotient    <= '1;
                        remainder   <= rem_q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else if (accept) begin
                        if (divisor == '0) begin
                            dbz_pend <= 1'b1;
                            rem_q    <= dividend;
                        end else begin
                            rem_q    <= '0;
                            quot_q   <= abs_dividend;
                            dsr_q    <= abs_divisor;
                            neg_quot <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_rem  <= dividend[WIDTH-1];
                            cnt      <= '0;
                            busy     <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt;
                    cnt    <= cnt + 6'd1;
                end
                FIX: begin
                    quotient    <= neg_quot ? -quot_q : quot_q;
                    remainder   <= neg_rem  ? -rem_q  : rem_q;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, expectations queued at launch, checked on done.
module tb_div_unit;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse retires the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    // Drive start for one cycle; returns at #1 after the accepting edge E0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        sb.push_back(e);
    endtask

    // Count edges until done is visible; flags latency and whether busy was ever seen.
    task automatic wait_done(input string name, input int exp_lat, input logic exp_busy);
        int   n = 0;
        logic busy_seen = busy;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy_seen"}, {31'd0, busy_seen}, {31'd0, exp_busy});
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dbz);
        push(q, r, dbz);
        launch(a, b);
        if (b == 32'd0) wait_done(name, 1, 1'b0);
        else            wait_done(name, 33, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        @(posedge clk);
        #1;

        run_op("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_op("n100_p7", -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        run_op("p100_n7", 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0);
        run_op("n100_n7", -32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE, 1'b0);
        run_op("min_n1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        run_op("p5_p9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        run_op("p42_zero", 32'd42, 32'd0, 32'hFFFFFFFF, 32'd42, 1'b1);
        run_op("p42_p6", 32'd42, 32'd6, 32'd7, 32'd0, 1'b0);
        run_op("n9_zero", -32'sd9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF7, 1'b1);

        // Abort 1000/3 with clear at cycle 20; outputs (dbz set above) must fall to zero.
        base = done_cnt;
        launch(32'd1000, 32'd3);
        repeat (19) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_dbz", {31'd0, div_by_zero}, 32'd0);
        check("clr_quotient", quotient, 32'd0);
        check("clr_remainder", remainder, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("clr_no_done", done_cnt, base);

        // Second start at cycle 10 of an operation is ignored.
        base = done_cnt;
        push(32'd333, 32'd1, 1'b0);
        launch(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_start", 23, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("ignored_single_done", done_cnt, base + 1);

        // Start issued in the done cycle is accepted.
        push(32'd4, 32'd1, 1'b0);
        launch(32'd9, 32'd2);
        wait_done("first_of_pair", 33, 1'b1);
        push(32'hFFFFFFFA, 32'd2, 1'b0);
        launch(32'd20, -32'sd3);
        wait_done("start_in_done", 33, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
